ct_f_spsram_arb_ctrl: RTL and testbench

- Sequencer and two-port arbiter in front of one single-port SRAM macro wrapper (1024x64, active-low CEN/GWEN/per-bit WEN, 1-cycle read latency).
- After reset it zero-fills the array. It then shares the macro between two requesters with round-robin arbitration and returns read data with a valid strobe.
- It sits between the cache/buffer logic and the SRAM wrapper; it drives A/CEN/D/GWEN/WEN directly and consumes Q.

---
 rtl/ct_f_spsram_arb_ctrl.sv | 136 +++++++++++++
 tb/tb_ct_f_spsram_arb_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_arb_ctrl.sv
// Zero-fill sequencer and round-robin two-port arbiter for a single-port SRAM macro.
// Drives the macro pins directly; read data returns one cycle after a granted read.
module ct_f_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] bmask0,
  input  logic [DATA_WIDTH-1:0] bmask1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvld0,
  output logic                  rvld1,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clr_req,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] Q
);

  typedef enum logic [1:0] {ST_WAIT, ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rr_last_q, rr_last_d;
  logic                    rvld0_q, rvld0_d;
  logic                    rvld1_q, rvld1_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   d_q, d_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      rvld0_q   <= 1'b0;
      rvld1_q   <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      rvld0_q   <= rvld0_d;
      rvld1_q   <= rvld1_d;
      a_q       <= a_d;
      d_q       <= d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    rvld0_d   = 1'b0;
    rvld1_d   = 1'b0;
    a_d       = a_q;
    d_d       = d_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    CEN       = 1'b1;
    GWEN      = 1'b1;
    WEN       = '1;
    unique case (state_q)
      ST_WAIT: begin
        cnt_d   = '0;
        state_d = (INIT_EN != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        CEN   = 1'b0;
        GWEN  = 1'b0;
        WEN   = '0;
        a_d   = cnt_q;
        d_d   = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        // rr_last_q=1 means port1 was served last, so port0 wins a tie
        gnt0 = req0 & (~req1 | rr_last_q);
        gnt1 = req1 & (~req0 | ~rr_last_q);
        if (gnt0) begin
          CEN       = 1'b0;
          a_d       = addr0;
          rr_last_d = 1'b0;
          if (wr0) begin
            GWEN = 1'b0;
            WEN  = ~bmask0;
            d_d  = wdata0;
          end else begin
            rvld0_d = 1'b1;
          end
        end else if (gnt1) begin
          CEN       = 1'b0;
          a_d       = addr1;
          rr_last_d = 1'b1;
          if (wr1) begin
            GWEN = 1'b0;
            WEN  = ~bmask1;
            d_d  = wdata1;
          end else begin
            rvld1_d = 1'b1;
          end
        end
        // The access granted this cycle still completes; the fill starts next cycle
        if (clr_req && (INIT_EN != 0)) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign A         = a_d;
  assign D         = d_d;
  assign rvld0     = rvld0_q;
  assign rvld1     = rvld1_q;
  assign rdata     = Q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
// Bench for ct_f_spsram_arb_ctrl: SRAM macro model, directed scenarios and a randomized
// two-requester phase checked against an array/queue-level reference of the arbiter.
module tb_ct_f_spsram_arb_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req0, req1, wr0, wr1, clr_req;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, bmask0, bmask1;
  logic          gnt0, gnt1, rvld0, rvld1, init_done;
  logic [DW-1:0] rdata;
  logic [AW-1:0] A;
  logic          CEN, GWEN;
  logic [DW-1:0] D, WEN, Q;

  logic          rst_n0, clr_n0;
  logic          gnt0_n0, gnt1_n0, rvld0_n0, rvld1_n0, init_done_n0, CEN_n0, GWEN_n0;
  logic [DW-1:0] rdata_n0, D_n0, WEN_n0;
  logic [3:0]    A_n0;

  always #5 CLK = ~CLK;

  ct_f_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .bmask0(bmask0), .bmask1(bmask1), .gnt0(gnt0), .gnt1(gnt1),
    .rvld0(rvld0), .rvld1(rvld1), .rdata(rdata), .clr_req(clr_req),
    .init_done(init_done), .A(A), .CEN(CEN), .D(D), .GWEN(GWEN), .WEN(WEN), .Q(Q)
  );

  ct_f_spsram_arb_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(DW), .INIT_EN(0)) dut_noinit (
    .CLK(CLK), .RST(rst_n0), .req0(1'b0), .req1(1'b0), .wr0(1'b0), .wr1(1'b0),
    .addr0(4'h0), .addr1(4'h0), .wdata0('0), .wdata1('0),
    .bmask0('0), .bmask1('0), .gnt0(gnt0_n0), .gnt1(gnt1_n0),
    .rvld0(rvld0_n0), .rvld1(rvld1_n0), .rdata(rdata_n0), .clr_req(clr_n0),
    .init_done(init_done_n0), .A(A_n0), .CEN(CEN_n0), .D(D_n0), .GWEN(GWEN_n0),
    .WEN(WEN_n0), .Q('0)
  );

  // SRAM macro model; junk_en preloads non-zero garbage so the zero-fill is observable
  logic [DW-1:0] sram [DEPTH];
  logic          junk_en;
  always @(posedge CLK) begin
    if (junk_en) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= {32'hA5A5_0000 | 32'(i), 32'h5A5A_5A5A};
    end else if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  // Reference state: expected array contents, last served port, outstanding read
  logic [DW-1:0] exp_mem [DEPTH];
  int            last_g;
  int            pend;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] a_hold;
  logic [DW-1:0] d_hold;
  logic          obs_gnt1;
  logic [DW-1:0] obs_rdata, obs_wen;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic [DW-1:0] m0,
                      input logic r1, input logic w1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1, input logic [DW-1:0] m1,
                      input logic clr, output int g);
    logic [AW-1:0] ga;
    logic          gw;
    logic [DW-1:0] gd, gm;
    req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0; bmask0 = m0;
    req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1; bmask1 = m1;
    clr_req = clr;
    @(negedge CLK);
    if (r0 && r1)  g = (last_g == 0) ? 1 : 0;
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    else           g = -1;
    obs_gnt1 = gnt1; obs_rdata = rdata; obs_wen = WEN;
    chk("gnt0", 64'(gnt0), 64'(g == 0));
    chk("gnt1", 64'(gnt1), 64'(g == 1));
    chk("rvld0", 64'(rvld0), 64'(pend == 0));
    chk("rvld1", 64'(rvld1), 64'(pend == 1));
    if (pend >= 0) chk("rdata", rdata, pend_data);
    chk("init_done_run", 64'(init_done), 64'd1);
    if (g < 0) begin
      chk("cen_idle", 64'(CEN), 64'd1);
      chk("a_hold", 64'(A), 64'(a_hold));
      chk("d_hold", D, d_hold);
      pend = -1;
    end else begin
      ga = (g == 1) ? a1 : a0;
      gw = (g == 1) ? w1 : w0;
      gd = (g == 1) ? d1 : d0;
      gm = (g == 1) ? m1 : m0;
      chk("cen_acc", 64'(CEN), 64'd0);
      chk("addr", 64'(A), 64'(ga));
      a_hold = ga;
      if (gw) begin
        chk("gwen_wr", 64'(GWEN), 64'd0);
        chk("wen_wr", WEN, ~gm);
        chk("wdata", D, gd);
        d_hold = gd;
        exp_mem[ga] = (exp_mem[ga] & ~gm) | (gd & gm);
        pend = -1;
      end else begin
        chk("gwen_rd", 64'(GWEN), 64'd1);
        chk("wen_rd", WEN, {DW{1'b1}});
        pend = g;
        pend_data = exp_mem[ga];
      end
      last_g = g;
    end
    @(posedge CLK); #1;
    clr_req = 1'b0;
  endtask

  task automatic wait_cycle();
    @(negedge CLK);
    chk("wait_cen", 64'(CEN), 64'd1);
    chk("wait_done", 64'(init_done), 64'd0);
    @(posedge CLK); #1;
  endtask

  // Walks the zero-fill; stop_at >= 0 asserts RST in that cycle instead of finishing
  task automatic run_init(input int stop_at);
    int bad_cen = 0, bad_a = 0, bad_w = 0, bad_g = 0;
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      if (CEN !== 1'b0) bad_cen++;
      if (A !== AW'(i)) bad_a++;
      if (GWEN !== 1'b0 || WEN !== '0 || D !== '0) bad_w++;
      if (gnt0 || gnt1 || init_done) bad_g++;
      if (i == stop_at) begin
        chk("abort_at_a", 64'(A), 64'(stop_at));
        RST = 1'b1;
        #1;
        chk("abort_cen", 64'(CEN), 64'd1);
        chk("abort_a", 64'(A), 64'd0);
        chk("abort_gwen", 64'(GWEN), 64'd1);
        chk("abort_wen", WEN, {DW{1'b1}});
        break;
      end
      @(posedge CLK); #1;
    end
    chk("init_cen_bad", 64'(bad_cen), 64'd0);
    chk("init_addr_bad", 64'(bad_a), 64'd0);
    chk("init_write_bad", 64'(bad_w), 64'd0);
    chk("init_gnt_bad", 64'(bad_g), 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    if (stop_at < 0) begin
      @(negedge CLK);
      chk("init_done_rise", 64'(init_done), 64'd1);
      chk("post_init_cen", 64'(CEN), 64'd1);
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
      a_hold = AW'(DEPTH - 1);
      d_hold = '0;
      pend   = -1;
      @(posedge CLK); #1;
    end
  endtask

  task automatic roll(output logic r, output logic w, output logic [AW-1:0] a,
                      output logic [DW-1:0] d, output logic [DW-1:0] m);
    r = ($urandom_range(0, 3) != 0);
    w = $urandom_range(0, 1) == 1;
    a = ($urandom_range(0, 7) == 0) ? AW'(10'h155) : AW'($urandom_range(0, 15));
    d = {$urandom, $urandom};
    m = ($urandom_range(0, 1) == 1) ? {DW{1'b1}} : {$urandom, $urandom};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic rr0, rw0, rr1, rw1;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rm0, rd1, rm1;
    RST = 1'b1; rst_n0 = 1'b1; clr_n0 = 1'b0; junk_en = 1'b0; clr_req = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; bmask0 = '0; bmask1 = '0;
    last_g = 1; pend = -1; a_hold = '0; d_hold = '0;
    repeat (2) @(posedge CLK);
    #1 junk_en = 1'b1;
    @(posedge CLK); #1 junk_en = 1'b0;

    // Reset values, with both requests raised
    req0 = 1'b1; req1 = 1'b1; addr0 = 10'h3FF; wdata0 = '1;
    @(negedge CLK);
    chk("rst_cen", 64'(CEN), 64'd1);
    chk("rst_gwen", 64'(GWEN), 64'd1);
    chk("rst_wen", WEN, {DW{1'b1}});
    chk("rst_a", 64'(A), 64'd0);
    chk("rst_d", D, 64'd0);
    chk("rst_gnt", 64'({gnt0, gnt1}), 64'd0);
    chk("rst_rvld", 64'({rvld0, rvld1}), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; wdata0 = '0;

    // INIT_EN=0 instance: RUN right after WAIT, no fill, clr_req ignored
    @(posedge CLK); #1 rst_n0 = 1'b0;
    @(negedge CLK);
    chk("n0_wait_done", 64'(init_done_n0), 64'd0);
    chk("n0_wait_cen", 64'(CEN_n0), 64'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("n0_run_done", 64'(init_done_n0), 64'd1);
    chk("n0_run_cen", 64'(CEN_n0), 64'd1);
    @(posedge CLK); #1 clr_n0 = 1'b1;
    @(posedge CLK); #1 clr_n0 = 1'b0;
    @(negedge CLK);
    chk("n0_clr_done", 64'(init_done_n0), 64'd1);
    chk("n0_clr_cen", 64'(CEN_n0), 64'd1);
    chk("n0_outs", 64'({gnt0_n0, gnt1_n0, rvld0_n0, rvld1_n0, GWEN_n0}), 64'd1);
    chk("n0_a", 64'(A_n0), 64'd0);
    chk("n0_d", D_n0, 64'd0);
    chk("n0_wen", WEN_n0, {DW{1'b1}});
    chk("n0_rdata", rdata_n0, 64'd0);

    // Main instance: WAIT, then the full fill
    @(posedge CLK); #1 RST = 1'b0;
    wait_cycle();
    run_init(-1);

    // Both ports holding requests: grants alternate starting at port0
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 10'd5, '0, '0, 1'b1, 1'b0, 10'd6, '0, '0, 1'b0, g);
      chk("alt_order", 64'(obs_gnt1), 64'(i % 2));
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);

    // Full write on port0 then read on port1 of the same address
    step(1'b1, 1'b1, 10'h155, 64'hDEADBEEF_CAFEF00D, '1, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 10'h155, '0, '0, 1'b0, g);
    chk("wr_rd_gnt1", 64'(obs_gnt1), 64'd1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    chk("wr_rd_data", obs_rdata, 64'hDEADBEEF_CAFEF00D);

    // Partial write to a zeroed address
    step(1'b1, 1'b1, 10'h2A0, '1, 64'h0000_0000_FFFF_0000, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    chk("partial_wen", obs_wen, 64'hFFFF_FFFF_0000_FFFF);
    step(1'b1, 1'b0, 10'h2A0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    chk("partial_rd", obs_rdata, 64'h0000_0000_FFFF_0000);

    // Randomized requesters that hold each request until it is granted
    roll(rr0, rw0, ra0, rd0, rm0);
    roll(rr1, rw1, ra1, rd1, rm1);
    for (int n = 0; n < 400; n++) begin
      step(rr0, rw0, ra0, rd0, rm0, rr1, rw1, ra1, rd1, rm1, 1'b0, g);
      if (g == 0 || !rr0) roll(rr0, rw0, ra0, rd0, rm0);
      if (g == 1 || !rr1) roll(rr1, rw1, ra1, rd1, rm1);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);

    // clr_req while a port1 read is granted
    step(1'b1, 1'b1, 10'h155, 64'h0123_4567_89AB_CDEF, '1, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 10'h155, '0, '0, 1'b1, g);
    #1;
    chk("clr_rvld1", 64'(rvld1), 64'd1);
    chk("clr_rdata", rdata, 64'h0123_4567_89AB_CDEF);
    chk("clr_done_drop", 64'(init_done), 64'd0);
    pend = -1;
    run_init(-1);
    step(1'b1, 1'b0, 10'h155, '0, '0, 1'b1, 1'b0, 10'h2A0, '0, '0, 1'b0, g);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 10'h155, '0, '0, 1'b0, g);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    chk("clr_zero_rd", obs_rdata, 64'd0);

    // RST drops a pending rvld, then aborts a fill at address 500
    step(1'b1, 1'b0, 10'd3, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);
    #1 RST = 1'b1;
    #1;
    chk("rst_drop_rvld", 64'({rvld0, rvld1}), 64'd0);
    chk("rst_mid_cen", 64'(CEN), 64'd1);
    @(posedge CLK); #1 RST = 1'b0;
    last_g = 1; pend = -1;
    wait_cycle();
    run_init(500);
    @(posedge CLK); #1 RST = 1'b0;
    wait_cycle();
    run_init(-1);
    step(1'b1, 1'b0, 10'd700, '0, '0, 1'b1, 1'b0, 10'd200, '0, '0, 1'b0, g);
    chk("post_abort_gnt1", 64'(obs_gnt1), 64'd0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 10'd200, '0, '0, 1'b0, g);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, g);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
